// File: rtl/tmds_channel_encoder.sv
// tmds_channel_encoder: one TMDS lane, 8b/10b video with DC balance, control, guard-band and TERC4 symbols
// Parameters: CHANNEL lane index (0 blue, 1 green, 2 red), CNT_W running-disparity width (>= 5)
// Ports: clk pixel clock; rst_n async active-low reset; mode period type (0 CTRL, 1 VIDEO,
//        2 VIDEO_GUARD, 3 DATA_GUARD, 4 TERC4); vd pixel byte; cd {C1,C0}; aux TERC4 nibble;
//        tmds 10-bit symbol (bit 0 first); disparity signed running disparity; mode_err illegal-mode flag
module tmds_channel_encoder #(
    parameter int CHANNEL = 0,
    parameter int CNT_W   = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [2:0]              mode,
    input  logic [7:0]              vd,
    input  logic [1:0]              cd,
    input  logic [3:0]              aux,
    output logic [9:0]              tmds,
    output logic signed [CNT_W-1:0] disparity,
    output logic                    mode_err
);
    localparam logic [15:0][9:0] TERC4 = {
        10'b1011000011, 10'b0101100011, 10'b1001110001, 10'b1010001110,
        10'b1011000110, 10'b0110011100, 10'b0100111001, 10'b1011001100,
        10'b0100111100, 10'b0110001110, 10'b0100011110, 10'b0101110001,
        10'b1011100010, 10'b1011100100, 10'b1001100011, 10'b1010011100
    };
    localparam logic [3:0][9:0] CTRL = {
        10'b1010101011, 10'b0101010100, 10'b0010101011, 10'b1101010100
    };
    localparam logic [9:0] GUARD_A = 10'b1011001100;
    localparam logic [9:0] GUARD_B = 10'b0100110011;

    logic [2:0]              mode_r;
    logic [1:0]              cd_r;
    logic [3:0]              aux_r;
    logic [8:0]              qm_r;
    logic [3:0]              vd_ones;
    logic                    use_xnor;
    logic [8:0]              qm;
    logic [3:0]              n1;
    logic                    bal;
    logic                    inv;
    logic signed [CNT_W-1:0] d;
    logic signed [CNT_W-1:0] cnt_v;
    logic signed [CNT_W-1:0] cnt_nx;
    logic [9:0]              sym_v;
    logic [9:0]              sym_nx;

    // Transition minimisation: each bit chains off the previous encoded bit
    always_comb begin
        vd_ones  = 4'($countones(vd));
        use_xnor = vd_ones > 4'd4 || (vd_ones == 4'd4 && !vd[0]);
        qm[0]    = vd[0];
        for (int i = 1; i < 8; i++)
            qm[i] = use_xnor ? ~(qm[i-1] ^ vd[i]) : qm[i-1] ^ vd[i];
        qm[8]    = !use_xnor;
    end

    // DC balance: d = n1 - n0 of q_m[7:0]; the sign bit alone separates cnt > 0 from cnt < 0
    // because cnt == 0 is already taken by the balanced branch
    always_comb begin
        n1     = 4'($countones(qm_r[7:0]));
        d      = CNT_W'({n1, 1'b0}) - CNT_W'(8);
        bal    = disparity == '0 || n1 == 4'd4;
        inv    = (!disparity[CNT_W-1] && n1 > 4'd4) || (disparity[CNT_W-1] && n1 < 4'd4);
        sym_v  = bal ? {~qm_r[8], qm_r[8], qm_r[8] ? qm_r[7:0] : ~qm_r[7:0]} :
                 inv ? {1'b1, qm_r[8], ~qm_r[7:0]} : {1'b0, qm_r[8], qm_r[7:0]};
        cnt_v  = bal ? (qm_r[8] ? disparity + d : disparity - d) :
                 inv ? disparity + (qm_r[8] ? CNT_W'(2) : '0) - d :
                       disparity + d - (qm_r[8] ? '0 : CNT_W'(2));
        cnt_nx = mode_r == 3'd1 ? cnt_v : '0;
        sym_nx = mode_r == 3'd1 ? sym_v :
                 mode_r == 3'd2 ? (CHANNEL == 1 ? GUARD_B : GUARD_A) :
                 mode_r == 3'd3 ? (CHANNEL == 0 ? TERC4[{2'b11, cd_r}] : GUARD_B) :
                 mode_r == 3'd4 ? TERC4[aux_r] : CTRL[cd_r];
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            mode_r    <= '0;
            cd_r      <= '0;
            aux_r     <= '0;
            qm_r      <= '0;
            tmds      <= CTRL[0];
            disparity <= '0;
            mode_err  <= 1'b0;
        end else begin
            mode_r    <= mode;
            cd_r      <= cd;
            aux_r     <= aux;
            qm_r      <= qm;
            tmds      <= sym_nx;
            disparity <= cnt_nx;
            mode_err  <= mode_r > 3'd4;
        end
endmodule

// File: tb/tb_tmds_channel_encoder.sv
// tb_tmds_channel_encoder: directed and reference-model checks of tmds_channel_encoder on lanes 0, 1 and 2
module tb_tmds_channel_encoder;
    logic              clk;
    logic              rst_n;
    logic [2:0]        mode;
    logic [7:0]        vd;
    logic [1:0]        cd;
    logic [3:0]        aux;
    logic [9:0]        t0, t1, t2;
    logic signed [4:0] d0, d1, d2;
    logic              e0, e1, e2;
    int                errs = 0;
    int                checks = 0;
    int                m_cnt;
    localparam int     N = 600;
    logic [9:0]        et [N];
    int                ed [N];

    tmds_channel_encoder #(.CHANNEL(0), .CNT_W(5)) u_ch0 (
        .clk(clk), .rst_n(rst_n), .mode(mode), .vd(vd), .cd(cd), .aux(aux),
        .tmds(t0), .disparity(d0), .mode_err(e0)
    );
    tmds_channel_encoder #(.CHANNEL(1), .CNT_W(5)) u_ch1 (
        .clk(clk), .rst_n(rst_n), .mode(mode), .vd(vd), .cd(cd), .aux(aux),
        .tmds(t1), .disparity(d1), .mode_err(e1)
    );
    tmds_channel_encoder #(.CHANNEL(2), .CNT_W(5)) u_ch2 (
        .clk(clk), .rst_n(rst_n), .mode(mode), .vd(vd), .cd(cd), .aux(aux),
        .tmds(t2), .disparity(d2), .mode_err(e2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errs++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic apply(input logic [2:0] m, input logic [7:0] v, input logic [1:0] c, input logic [3:0] a);
        @(negedge clk);
        mode = m;
        vd   = v;
        cd   = c;
        aux  = a;
        repeat (2) @(negedge clk);
    endtask

    // Textbook DVI 1.0 encoder written with plain integer arithmetic
    task automatic ref_video(input logic [7:0] v, output logic [9:0] r);
        int         n, n1, n0;
        logic       x;
        logic [8:0] q;
        n    = $countones(v);
        x    = n > 4 || (n == 4 && v[0] == 1'b0);
        q[0] = v[0];
        for (int i = 1; i < 8; i++) q[i] = q[i-1] ^ v[i] ^ x;
        q[8] = !x;
        n1   = $countones(q[7:0]);
        n0   = 8 - n1;
        if (m_cnt == 0 || n1 == n0) begin
            r = {~q[8], q[8], q[8] ? q[7:0] : ~q[7:0]};
            m_cnt += q[8] ? n1 - n0 : n0 - n1;
        end else if ((m_cnt > 0 && n1 > n0) || (m_cnt < 0 && n0 > n1)) begin
            r = {1'b1, q[8], ~q[7:0]};
            m_cnt += (q[8] ? 2 : 0) + n0 - n1;
        end else begin
            r = {1'b0, q[8], q[7:0]};
            m_cnt += n1 - n0 - (q[8] ? 0 : 2);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        mode  = 3'd1;
        vd    = 8'hff;
        cd    = 2'b11;
        aux   = 4'h0;
        repeat (3) @(negedge clk);
        check("rst_tmds", t0, 10'b1101010100);
        check("rst_disp", d0, 0);
        check("rst_err", e0, 0);
        check("rst_tmds_ch1", t1, 10'b1101010100);
        mode  = 3'd0;
        rst_n = 1'b1;
        @(negedge clk);
        check("first_sym", t0, 10'b1101010100);
        @(negedge clk);
        check("ctrl11", t0, 10'b1010101011);
        check("ctrl11_disp", d0, 0);

        apply(3'd0, 8'h00, 2'b01, 4'h0);
        check("ctrl01", t0, 10'b0010101011);
        apply(3'd0, 8'h00, 2'b10, 4'h0);
        check("ctrl10", t0, 10'b0101010100);

        @(negedge clk);
        mode = 3'd1;
        vd   = 8'h00;
        repeat (2) @(negedge clk);
        check("vid00_a", t0, 10'b0100000000);
        check("vid00_a_disp", d0, -8);
        @(negedge clk);
        check("vid00_b", t0, 10'b1111111111);
        check("vid00_b_disp", d0, 2);

        apply(3'd4, 8'h00, 2'b00, 4'hA);
        check("terc_a_ch0", t0, 10'b0110011100);
        check("terc_a_ch1", t1, 10'b0110011100);
        check("terc_a_ch2", t2, 10'b0110011100);
        check("terc_a_disp", d0, 0);
        apply(3'd4, 8'h00, 2'b00, 4'h0);
        check("terc_0_ch0", t0, 10'b1010011100);
        check("terc_0_disp", d0, 0);

        apply(3'd2, 8'h00, 2'b00, 4'h0);
        check("vguard_ch0", t0, 10'b1011001100);
        check("vguard_ch1", t1, 10'b0100110011);
        check("vguard_ch2", t2, 10'b1011001100);
        check("vguard_disp1", d1, 0);
        apply(3'd3, 8'h00, 2'b10, 4'h0);
        check("dguard_ch0", t0, 10'b0101100011);
        check("dguard_ch1", t1, 10'b0100110011);
        check("dguard_ch2", t2, 10'b0100110011);
        check("dguard_disp2", d2, 0);

        apply(3'd0, 8'h00, 2'b00, 4'h0);
        @(negedge clk);
        mode = 3'd7;
        cd   = 2'b01;
        @(negedge clk);
        mode = 3'd0;
        @(negedge clk);
        check("illegal_err", e0, 1);
        check("illegal_tmds", t0, 10'b0010101011);
        check("illegal_err_ch2", e2, 1);
        @(negedge clk);
        check("illegal_err_clr", e0, 0);
        check("illegal_err_clr_ch1", e1, 0);

        cd    = 2'b00;
        m_cnt = 0;
        for (int i = 0; i < N + 2; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                check("rnd_tmds", t0, et[i-2]);
                check("rnd_disp", d0, ed[i-2]);
                check("rnd_bound", (d0 <= 10 && d0 >= -10) ? 1 : 0, 1);
            end
            if (i < N) begin
                if (i % 37 == 5) begin
                    mode  = 3'd0;
                    et[i] = 10'b1101010100;
                    m_cnt = 0;
                    ed[i] = 0;
                end else begin
                    mode = 3'd1;
                    vd   = 8'($urandom);
                    ref_video(vd, et[i]);
                    ed[i] = m_cnt;
                end
            end
        end

        apply(3'd0, 8'h00, 2'b00, 4'h0);
        @(negedge clk);
        mode = 3'd1;
        vd   = 8'h00;
        repeat (2) @(negedge clk);
        check("pre_arst_disp", d0, -8);
        #2 rst_n = 1'b0;
        #1;
        check("arst_tmds", t0, 10'b1101010100);
        check("arst_disp", d0, 0);
        check("arst_err", e0, 0);
        @(negedge clk);
        mode  = 3'd0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_arst", t0, 10'b1101010100);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
